// File: rtl/interp_scheduler.sv
// Sequencer for the 10x interpolator path: derives the 480k/48k enables, loads the
// x0/x1 pair, double-buffers output frames and replays them one sample per fast tick.
module interp_scheduler #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DIV_BASE     = 100,
  parameter int RATIO        = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       src_sample,
  output logic                          src_req,
  output logic [SAMPLE_WIDTH-1:0]       x0,
  output logic [SAMPLE_WIDTH-1:0]       x1,
  output logic                          clk_en,
  output logic                          clk_en_10x,
  input  logic                          end_stage,
  input  logic [RATIO*SAMPLE_WIDTH-1:0] y_bus,
  output logic [SAMPLE_WIDTH-1:0]       out_sample,
  output logic                          out_valid,
  output logic                          running,
  output logic                          underrun
);
  localparam int DW = $clog2(DIV_BASE);
  localparam int FW = RATIO * SAMPLE_WIDTH;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_BASE - 1);
  localparam logic [3:0]    PHASE_LAST = 4'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [DW-1:0]           div_cnt_reg, div_cnt_next;
  logic [3:0]              phase_reg, phase_next;
  logic [1:0]              loads_reg, loads_next;
  logic                    shadow_full_reg, shadow_full_next;
  logic [FW-1:0]           shadow_reg, shadow_next;
  logic [FW-1:0]           active_reg, active_next;
  logic [SAMPLE_WIDTH-1:0] x0_reg, x0_next;
  logic [SAMPLE_WIDTH-1:0] x1_reg, x1_next;
  logic [SAMPLE_WIDTH-1:0] out_sample_reg, out_sample_next;
  logic                    underrun_reg, underrun_next;

  logic                    tick, frame_tick, swap, swap_data, replay;
  logic [3:0]              replay_idx;
  logic [SAMPLE_WIDTH-1:0] active_elem [RATIO];

  // Strobes are decoded from registered state so an async reset drops them at once.
  assign tick       = (state_reg != IDLE) && (div_cnt_reg == DIV_LAST);
  assign frame_tick = tick && (phase_reg == PHASE_LAST);
  assign swap       = frame_tick && (loads_reg == 2'd2);
  assign swap_data  = swap && (end_stage || shadow_full_reg);
  assign replay     = tick && ((state_reg == RUN) || ((state_reg == PRIME) && swap_data));
  assign replay_idx = (phase_reg == PHASE_LAST) ? 4'd0 : phase_reg + 4'd1;

  assign clk_en_10x = tick;
  assign clk_en     = frame_tick;
  assign src_req    = frame_tick;
  assign out_valid  = replay;
  assign running    = (state_reg == RUN);
  assign underrun   = underrun_reg;
  assign x0         = x0_reg;
  assign x1         = x1_reg;
  assign out_sample = out_sample_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_elem
      assign active_elem[gi] = active_next[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    div_cnt_next     = div_cnt_reg;
    phase_next       = phase_reg;
    loads_next       = loads_reg;
    shadow_full_next = shadow_full_reg;
    shadow_next      = shadow_reg;
    active_next      = active_reg;
    x0_next          = x0_reg;
    x1_next          = x1_reg;
    underrun_next    = underrun_reg;
    if (state_reg == IDLE) begin
      div_cnt_next     = '0;
      phase_next       = '0;
      loads_next       = '0;
      shadow_full_next = 1'b0;
      if (enable) begin
        state_next    = PRIME;
        underrun_next = 1'b0;
      end
    end else begin
      div_cnt_next = tick ? '0 : div_cnt_reg + DW'(1);
      if (tick)
        phase_next = (phase_reg == PHASE_LAST) ? 4'd0 : phase_reg + 4'd1;
      if (frame_tick) begin
        x1_next = src_sample;
        x0_next = x1_reg;
        if (loads_reg != 2'd2)
          loads_next = loads_reg + 2'd1;
      end
      // A frame arriving in the swap cycle bypasses the shadow buffer.
      if (swap) begin
        if (end_stage)
          active_next = y_bus;
        else if (shadow_full_reg)
          active_next = shadow_reg;
        else if (state_reg == RUN)
          underrun_next = 1'b1;
        shadow_full_next = 1'b0;
      end else if (end_stage) begin
        shadow_next      = y_bus;
        shadow_full_next = 1'b1;
      end
      if ((state_reg == PRIME) && swap_data)
        state_next = RUN;
      if (!enable)
        state_next = IDLE;
    end
  end

  always_comb begin
    out_sample_next = out_sample_reg;
    if (replay)
      out_sample_next = active_elem[replay_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      div_cnt_reg     <= '0;
      phase_reg       <= '0;
      loads_reg       <= '0;
      shadow_full_reg <= 1'b0;
      shadow_reg      <= '0;
      active_reg      <= '0;
      x0_reg          <= '0;
      x1_reg          <= '0;
      out_sample_reg  <= '0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      div_cnt_reg     <= div_cnt_next;
      phase_reg       <= phase_next;
      loads_reg       <= loads_next;
      shadow_full_reg <= shadow_full_next;
      shadow_reg      <= shadow_next;
      active_reg      <= active_next;
      x0_reg          <= x0_next;
      x1_reg          <= x1_next;
      out_sample_reg  <= out_sample_next;
      underrun_reg    <= underrun_next;
    end
  end
endmodule

// File: tb/tb_interp_scheduler.sv
// Bench for interp_scheduler: directed vector table, hand-written enable/reset sequences,
// then randomized traffic checked every cycle against a frame-level reference model.
module tb_interp_scheduler;
  localparam int SW = 8, DIV = 100, RATIO = 10, FW = SW * RATIO, FRAME = DIV * RATIO;

  logic clk = 1'b0;
  logic reset, enable, end_stage;
  logic [SW-1:0] src_sample;
  logic [FW-1:0] y_bus;
  logic src_req, clk_en, clk_en_10x, out_valid, running, underrun;
  logic [SW-1:0] x0, x1, out_sample;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  interp_scheduler #(.SAMPLE_WIDTH(SW), .DIV_BASE(DIV), .RATIO(RATIO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .src_sample(src_sample), .src_req(src_req),
    .x0(x0), .x1(x1), .clk_en(clk_en), .clk_en_10x(clk_en_10x), .end_stage(end_stage),
    .y_bus(y_bus), .out_sample(out_sample), .out_valid(out_valid), .running(running),
    .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [29:0] outs();
    return {src_req, clk_en, clk_en_10x, out_valid, running, underrun, x0, x1, out_sample};
  endfunction

  function automatic logic [FW-1:0] mk_y(input logic [SW-1:0] base);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < RATIO; i++) v[i*SW +: SW] = base + SW'(i);
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef enum int {S_TICK, S_CE, S_REQ, S_X0, S_X1, S_OUT, S_VAL, S_RUN, S_UND} sig_e;
  typedef struct {
    int         cyc;
    logic       es;
    logic [7:0] src;
    logic [7:0] ybase;
    sig_e       sig;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int c, input logic es, input logic [7:0] src,
                              input logic [7:0] yb, input sig_e s, input logic [7:0] e);
    vec_t v;
    v.cyc = c; v.es = es; v.src = src; v.ybase = yb; v.sig = s; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] pick(input sig_e s);
    logic [7:0] v;
    v = 8'h00;
    case (s)
      S_TICK:  v = {7'd0, clk_en_10x};
      S_CE:    v = {7'd0, clk_en};
      S_REQ:   v = {7'd0, src_req};
      S_X0:    v = x0;
      S_X1:    v = x1;
      S_OUT:   v = out_sample;
      S_VAL:   v = {7'd0, out_valid};
      S_RUN:   v = {7'd0, running};
      S_UND:   v = {7'd0, underrun};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic          m_on, m_run, m_under, m_pend;
  int            m_t;
  logic [SW-1:0] m_x0, m_x1, m_out;
  logic [SW-1:0] m_act [RATIO];
  logic [SW-1:0] m_sh  [RATIO];

  task automatic model_reset();
    m_on = 0; m_run = 0; m_under = 0; m_pend = 0; m_t = 0;
    m_x0 = '0; m_x1 = '0; m_out = '0;
    for (int i = 0; i < RATIO; i++) begin m_act[i] = '0; m_sh[i] = '0; end
  endtask

  function automatic logic m_tick();
    return m_on && (m_t % DIV == DIV - 1);
  endfunction

  function automatic logic m_frame();
    return m_on && (m_t % FRAME == FRAME - 1);
  endfunction

  // Two source samples must have arrived before a frame boundary can swap.
  function automatic logic m_swap();
    return m_frame() && (m_t / FRAME >= 2);
  endfunction

  function automatic logic [29:0] model_exp(input logic es);
    logic valid;
    valid = m_tick() && (m_run || (m_swap() && (es || m_pend)));
    return {m_frame(), m_frame(), m_tick(), valid, m_run, m_under, m_x0, m_x1, m_out};
  endfunction

  task automatic model_step(input logic en, input logic es, input logic [FW-1:0] y,
                            input logic [SW-1:0] src);
    logic valid, sw, has;
    if (!m_on) begin
      if (en) begin m_on = 1; m_t = 0; m_under = 0; m_pend = 0; end
    end else begin
      sw    = m_swap();
      has   = es || m_pend;
      valid = m_tick() && (m_run || (sw && has));
      if (m_frame()) begin m_x0 = m_x1; m_x1 = src; end
      if (sw) begin
        if (es) for (int i = 0; i < RATIO; i++) m_act[i] = y[i*SW +: SW];
        else if (m_pend) m_act = m_sh;
        else if (m_run) m_under = 1;
        if (has) begin m_pend = 0; m_run = 1; end
      end else if (es) begin
        for (int i = 0; i < RATIO; i++) m_sh[i] = y[i*SW +: SW];
        m_pend = 1;
      end
      if (valid) m_out = m_act[((m_t / DIV) % RATIO + 1) % RATIO];
      m_t++;
      if (!en) begin m_on = 0; m_run = 0; end
    end
  endtask

  initial begin
    int n, first_ce, rate;
    logic en_mode;
    logic [95:0] r96;
    logic [29:0] exp_v;
    int rates[4] = '{0, 2, 4, 12};

    reset = 1; enable = 0; end_stage = 0; src_sample = '0; y_bus = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_outs", 32'(outs()), 32'd0);
    reset = 0;
    step();
    @(negedge clk);
    check("idle_outs", 32'(outs()), 32'd0);

    add(98,   0, 8'h00, 8'h00, S_TICK, 8'd0);
    add(99,   0, 8'h00, 8'h00, S_TICK, 8'd1);
    add(99,   0, 8'h00, 8'h00, S_VAL,  8'd0);
    add(199,  0, 8'h00, 8'h00, S_TICK, 8'd1);
    add(998,  0, 8'h00, 8'h00, S_CE,   8'd0);
    add(999,  0, 8'h11, 8'h00, S_CE,   8'd1);
    add(999,  0, 8'h11, 8'h00, S_REQ,  8'd1);
    add(1999, 0, 8'h22, 8'h00, S_X1,   8'h11);
    add(1999, 0, 8'h22, 8'h00, S_CE,   8'd1);
    add(2000, 0, 8'h00, 8'h00, S_X1,   8'h22);
    add(2000, 0, 8'h00, 8'h00, S_X0,   8'h11);
    add(2500, 1, 8'h00, 8'h00, S_UND,  8'd0);
    add(2999, 0, 8'h00, 8'h00, S_VAL,  8'd1);
    add(2999, 0, 8'h00, 8'h00, S_RUN,  8'd0);
    add(3000, 0, 8'h00, 8'h00, S_RUN,  8'd1);
    add(3000, 0, 8'h00, 8'h00, S_OUT,  8'h00);
    add(3099, 0, 8'h00, 8'h00, S_VAL,  8'd1);
    add(3100, 0, 8'h00, 8'h00, S_OUT,  8'h01);
    add(3900, 0, 8'h00, 8'h00, S_OUT,  8'h09);
    add(3999, 1, 8'h00, 8'h40, S_VAL,  8'd1);
    add(4000, 0, 8'h00, 8'h00, S_OUT,  8'h40);
    add(4000, 0, 8'h00, 8'h00, S_UND,  8'd0);
    add(4100, 0, 8'h00, 8'h00, S_OUT,  8'h41);
    add(4999, 0, 8'h00, 8'h00, S_VAL,  8'd1);
    add(5000, 0, 8'h00, 8'h00, S_UND,  8'd1);
    add(5000, 0, 8'h00, 8'h00, S_OUT,  8'h40);
    add(5100, 0, 8'h00, 8'h00, S_OUT,  8'h41);
    add(5200, 1, 8'h00, 8'h60, S_UND,  8'd1);
    add(5300, 1, 8'h00, 8'h80, S_RUN,  8'd1);
    add(6000, 0, 8'h00, 8'h00, S_OUT,  8'h80);
    add(6100, 0, 8'h00, 8'h00, S_OUT,  8'h81);

    enable = 1;
    step();
    cyc = 0;
    for (int c = 0; c <= 6100; c++) begin
      end_stage = 0; src_sample = '0; y_bus = '0;
      foreach (tbl[i]) if (tbl[i].cyc == c) begin
        if (tbl[i].es) begin end_stage = 1; y_bus = mk_y(tbl[i].ybase); end
        if (tbl[i].src != 8'h00) src_sample = tbl[i].src;
      end
      @(negedge clk);
      foreach (tbl[i]) if (tbl[i].cyc == c) begin
        check($sformatf("vec%0d_cyc%0d", i, c), 32'(pick(tbl[i].sig)), 32'(tbl[i].exp));
        $display("vec %0d cyc %0d sig %0d got 0x%0h want 0x%0h", i, c, int'(tbl[i].sig),
                 pick(tbl[i].sig), tbl[i].exp);
      end
      step();
    end
    end_stage = 0; src_sample = '0; y_bus = '0;

    // enable dropped mid-frame, then re-enabled
    while (cyc < 6150) step();
    enable = 0;
    step();
    @(negedge clk);
    check("idle_running", 32'(running), 32'd0);
    check("idle_underrun_held", 32'(underrun), 32'd1);
    n = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      @(negedge clk);
      if (clk_en_10x || clk_en || src_req || out_valid) n++;
    end
    check("idle_no_strobes", 32'(n), 32'd0);
    $display("seq idle: %0d strobe cycles while disabled", n);
    enable = 1;
    step();
    cyc = 0;
    first_ce = -1;
    while (cyc <= 3099) begin
      end_stage = (cyc == 2500);
      y_bus = mk_y(8'hA0);
      @(negedge clk);
      if (cyc == 0) check("reenable_underrun_clear", 32'(underrun), 32'd0);
      if (clk_en && first_ce < 0) first_ce = cyc;
      if (cyc == 2999) check("reenable_swap_valid", 32'(out_valid), 32'd1);
      if (cyc == 3000) check("reenable_out_y0", 32'(out_sample), 32'hA0);
      if (cyc == 3099) break;
      step();
    end
    end_stage = 0;
    check("reenable_first_ce", 32'(first_ce), 32'd999);
    $display("seq reenable: first clk_en at cycle %0d", first_ce);

    // async reset mid-RUN, applied away from any clock edge
    check("run_running", 32'(running), 32'd1);
    check("run_valid_before_rst", 32'(out_valid), 32'd1);
    #2 reset = 1;
    #1 check("async_reset_outs", 32'(outs()), 32'd0);
    $display("seq async reset: outs 0x%0h", outs());
    @(posedge clk);
    #1 reset = 0;
    model_reset();

    // randomized traffic against the reference model
    en_mode = 1;
    rate = 4;
    for (int c = 0; c < 40000; c++) begin
      if (en_mode) begin
        if ($urandom_range(0, 4999) == 0) en_mode = 0;
      end else if ($urandom_range(0, 49) == 0) en_mode = 1;
      if (c % 5000 == 0) rate = rates[$urandom_range(0, 3)];
      enable = en_mode;
      reset = ($urandom_range(0, 14999) == 0);
      src_sample = SW'($urandom);
      r96 = {$urandom, $urandom, $urandom};
      y_bus = r96[FW-1:0];
      end_stage = (int'($urandom_range(0, 999)) < rate) ||
                  (m_frame() && ($urandom_range(0, 2) == 0));
      exp_v = reset ? 30'd0 : model_exp(end_stage);
      @(negedge clk);
      check($sformatf("rand_cyc%0d", c), 32'(outs()), 32'(exp_v));
      if (clk_en && !reset)
        $display("rand cyc %0d frame: x1=0x%0h out=0x%0h run=%0d und=%0d", c, x1, out_sample,
                 running, underrun);
      if (reset) model_reset();
      else model_step(enable, end_stage, y_bus, src_sample);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
